// File: rtl/adsr_pkg.sv
// Shared types and constants for the ADSR envelope sequencer.
// Envelope levels are Q2.14 (env) over a 32-bit accumulator (acc).
package adsr_pkg;

  typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} adsr_state_t;

  localparam logic [15:0] ENV_MAX = 16'h4000;
  localparam logic [31:0] ACC_MAX = 32'h4000_0000;

endpackage

// File: rtl/adsr_ctrl.sv
// Attack/decay/sustain/release envelope sequencer; steps once per step_en tick.
// Optional build macro ADSR_HARD_RETRIG_EN: a retrigger rise clears acc before ATTACK.
//
// state   | meaning
// IDLE    | no note, acc held at 0
// ATTACK  | ramp up by attack_step per tick until full scale
// DECAY   | ramp down by decay_step per tick until sustain level
// SUSTAIN | acc follows live sustain level
// RELEASE | ramp down by release_step per tick until 0, then pulse done
module adsr_ctrl
  import adsr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        step_en,
  input  logic        gate,
  input  logic [31:0] attack_step,
  input  logic [31:0] decay_step,
  input  logic [15:0] sustain_lvl,
  input  logic [31:0] release_step,
  output logic [15:0] env,
  output logic        busy,
  output logic        done
);

  adsr_state_t state, state_nxt;
  logic [31:0] acc, acc_nxt;
  logic        gate_d;
  logic        done_nxt;
  logic        rise, fall;
  logic [31:0] sus_acc;
  logic [32:0] att_sum;
  logic [32:0] dec_diff;

  assign rise     = gate & ~gate_d;
  assign fall     = ~gate & gate_d;
  assign sus_acc  = (sustain_lvl > ENV_MAX) ? {ENV_MAX, 16'h0000} : {sustain_lvl, 16'h0000};
  assign att_sum  = {1'b0, acc} + {1'b0, attack_step};
  // Bit 32 of the difference is the borrow, which counts as "at or below sustain".
  assign dec_diff = {1'b0, acc} - {1'b0, decay_step};

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    done_nxt  = 1'b0;
    if (rise) begin
      state_nxt = ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
      acc_nxt = '0;
`endif
    end else if (fall) begin
      if (state == ATTACK || state == DECAY || state == SUSTAIN)
        state_nxt = RELEASE;
    end else if (step_en) begin
      case (state)
        IDLE: acc_nxt = '0;
        ATTACK: begin
          if (attack_step == '0 || att_sum >= {1'b0, ACC_MAX}) begin
            acc_nxt   = ACC_MAX;
            state_nxt = DECAY;
          end else begin
            acc_nxt = att_sum[31:0];
          end
        end
        DECAY: begin
          if (decay_step == '0 || dec_diff[32] || dec_diff[31:0] <= sus_acc) begin
            acc_nxt   = sus_acc;
            state_nxt = SUSTAIN;
          end else begin
            acc_nxt = dec_diff[31:0];
          end
        end
        SUSTAIN: acc_nxt = sus_acc;
        RELEASE: begin
          if (release_step == '0 || acc <= release_step) begin
            acc_nxt   = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            acc_nxt = acc - release_step;
          end
        end
        default: begin
          acc_nxt   = '0;
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so env, busy and done
  // move on the same edge as the accumulator and state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      gate_d <= 1'b0;
      env    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      gate_d <= gate;
      env    <= acc_nxt[31:16];
      busy   <= (state_nxt != IDLE);
      done   <= done_nxt;
    end
  end

endmodule
